// File: rtl/rv32i_memory_stage_pkg.sv
// Shared encodings, state codes and the DM/WB payload type for the RV32I memory stage.
package rv32i_memory_stage_pkg;

    // Store size encoding carried on MemWriteM
    localparam logic [1:0] MEMWRITE_NONE = 2'b00;
    localparam logic [1:0] MEMWRITE_SB   = 2'b01;
    localparam logic [1:0] MEMWRITE_SH   = 2'b10;
    localparam logic [1:0] MEMWRITE_SW   = 2'b11;

    // Load size encoding (funct3) carried on LoadSizeM
    localparam logic [2:0] LOADSIZE_LB  = 3'b000;
    localparam logic [2:0] LOADSIZE_LH  = 3'b001;
    localparam logic [2:0] LOADSIZE_LW  = 3'b010;
    localparam logic [2:0] LOADSIZE_LBU = 3'b100;
    localparam logic [2:0] LOADSIZE_LHU = 3'b101;

    // Writeback source select
    localparam logic [1:0] RESULTSRC_ALU  = 2'b00;
    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;
    localparam logic [1:0] RESULTSRC_PC4  = 2'b10;

    // Access FSM states
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Contents of the DM/WB pipeline register
    typedef struct packed {
        logic        reg_write;
        logic [1:0]  result_src;
        logic [31:0] alu_result;
        logic [31:0] read_data;
        logic [31:0] pc_plus4;
        logic [4:0]  rd;
    } dm_wb_t;

    localparam dm_wb_t DM_WB_BUBBLE = '{
        reg_write:  1'b0,
        result_src: 2'b00,
        alu_result: 32'h0000_0000,
        read_data:  32'h0000_0000,
        pc_plus4:   32'h0000_0000,
        rd:         5'd0
    };

    // True when a halfword access is odd or a word access is not word aligned
    function automatic logic is_misaligned(input logic       is_load,
                                           input logic [1:0] mem_write,
                                           input logic [2:0] load_size,
                                           input logic [1:0] addr_lo);
        logic half_acc;
        logic word_acc;
        half_acc = (is_load && (load_size[1:0] == 2'b01)) || (mem_write == MEMWRITE_SH);
        word_acc = (is_load && (load_size[1:0] == 2'b10)) || (mem_write == MEMWRITE_SW);
        return (half_acc && addr_lo[0]) || (word_acc && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/rv32i_memory_stage_dm_wb_reg.sv
// DM/WB pipeline register. A bubble (all fields zero, no register write) is
// loaded on reset or whenever the M stage does not retire an instruction.
module dm_wb_reg
    import rv32i_memory_stage_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   bubble,
    input  dm_wb_t d,
    output dm_wb_t q
);

    dm_wb_t q_r;

    // Capture the retiring M instruction, or a bubble when nothing retires
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= DM_WB_BUBBLE;
        end else if (bubble) begin
            q_r <= DM_WB_BUBBLE;
        end else begin
            q_r <= d;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/rv32i_memory_stage.sv
// RV32I memory stage: drives a variable-latency data-memory port, builds store
// lanes/byte-enables, aligns and extends load data, stalls the pipeline while an
// access is outstanding and feeds the DM/WB register.
// BusErrM is registered so that it lines up with the bubble it accompanies in W.
// ReadDataW is zero for instructions that are not loads.
// Optional build macro: MISALIGN_TRAP_EN (misaligned half/word accesses are not
// issued and raise BusErrM instead).
module rv32i_memory_stage
    import rv32i_memory_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [1:0]  MemWriteM,
    input  logic [2:0]  LoadSizeM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] PCPlus4M,
    input  logic [4:0]  RdM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        StallM,
    output logic        BusErrM,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W,
    output logic [4:0]  RdW
);

    localparam int               CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             is_load_s;
    logic             is_store_s;
    logic             mem_op_s;
    logic             misalign_s;
    logic             issue_s;
    logic             timeout_hit_s;
    logic             abandon_s;
    logic             stall_s;
    logic             bubble_s;
    logic [7:0]       byte_s;
    logic [15:0]      half_s;
    logic [31:0]      load_data_s;
    logic [3:0]       be_s;
    logic [31:0]      wdata_s;
    logic [0:0]       state_r;
    logic [0:0]       state_nxt_s;
    logic [CNT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0] wait_cnt_nxt_s;
    logic             bus_err_r;
    dm_wb_t           w_next_s;
    dm_wb_t           w_q_s;

    assign is_load_s  = (ResultSrcM == RESULTSRC_LOAD);
    assign is_store_s = (MemWriteM != MEMWRITE_NONE);
    assign mem_op_s   = is_load_s | is_store_s;

`ifdef MISALIGN_TRAP_EN
    assign misalign_s = mem_op_s & is_misaligned(is_load_s, MemWriteM, LoadSizeM, ALUResultM[1:0]);
`else
    assign misalign_s = 1'b0;
`endif

    // A trapped access never reaches the memory port
    assign issue_s       = mem_op_s & ~misalign_s;
    assign timeout_hit_s = (TIMEOUT != 32'sd0) && (state_r == ST_WAIT) && (wait_cnt_r == TIMEOUT_C);
    assign abandon_s     = issue_s & ~dmem_ready & timeout_hit_s;
    assign stall_s       = issue_s & ~dmem_ready & ~abandon_s;
    assign bubble_s      = stall_s | abandon_s | misalign_s;

    // The request is a direct function of the held M instruction, so address and
    // lanes stay stable for as long as the pipeline is frozen
    assign dmem_req   = issue_s;
    assign dmem_we    = is_store_s;
    assign dmem_addr  = {ALUResultM[31:2], 2'b00};
    assign dmem_be    = be_s;
    assign dmem_wdata = wdata_s;
    assign StallM     = stall_s;
    assign BusErrM    = bus_err_r;

    // Store byte enables and lane-replicated write data
    always_comb begin
        be_s    = 4'b1111;
        wdata_s = WriteDataM;
        case (MemWriteM)
            MEMWRITE_SB: begin
                be_s    = 4'b0001 << ALUResultM[1:0];
                wdata_s = {4{WriteDataM[7:0]}};
            end
            MEMWRITE_SH: begin
                if (ALUResultM[1]) begin
                    be_s = 4'b1100;
                end else begin
                    be_s = 4'b0011;
                end
                wdata_s = {2{WriteDataM[15:0]}};
            end
            MEMWRITE_SW: begin
                be_s    = 4'b1111;
                wdata_s = WriteDataM;
            end
            default: begin
                be_s    = 4'b1111;
                wdata_s = WriteDataM;
            end
        endcase
    end

    // Pick the addressed byte and halfword out of the read word
    always_comb begin
        byte_s = dmem_rdata[7:0];
        half_s = dmem_rdata[15:0];
        case (ALUResultM[1:0])
            2'b00:   byte_s = dmem_rdata[7:0];
            2'b01:   byte_s = dmem_rdata[15:8];
            2'b10:   byte_s = dmem_rdata[23:16];
            2'b11:   byte_s = dmem_rdata[31:24];
            default: byte_s = dmem_rdata[7:0];
        endcase
        if (ALUResultM[1]) begin
            half_s = dmem_rdata[31:16];
        end else begin
            half_s = dmem_rdata[15:0];
        end
    end

    // Sign/zero extension by load size; non-loads carry zero read data
    always_comb begin
        load_data_s = 32'h0000_0000;
        if (is_load_s) begin
            case (LoadSizeM)
                LOADSIZE_LB:  load_data_s = {{24{byte_s[7]}}, byte_s};
                LOADSIZE_LH:  load_data_s = {{16{half_s[15]}}, half_s};
                LOADSIZE_LW:  load_data_s = dmem_rdata;
                LOADSIZE_LBU: load_data_s = {24'h00_0000, byte_s};
                LOADSIZE_LHU: load_data_s = {16'h0000, half_s};
                default:      load_data_s = dmem_rdata;
            endcase
        end else begin
            load_data_s = 32'h0000_0000;
        end
    end

    // Next state and wait count; the count is the number of WAIT cycles seen so far
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (issue_s && !dmem_ready) begin
                    state_nxt_s    = ST_WAIT;
                    wait_cnt_nxt_s = CNT_ONE;
                end else begin
                    state_nxt_s    = ST_IDLE;
                    wait_cnt_nxt_s = CNT_ZERO;
                end
            end
            ST_WAIT: begin
                if (dmem_ready || abandon_s || !issue_s) begin
                    state_nxt_s    = ST_IDLE;
                    wait_cnt_nxt_s = CNT_ZERO;
                end else begin
                    state_nxt_s    = ST_WAIT;
                    wait_cnt_nxt_s = wait_cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                wait_cnt_nxt_s = CNT_ZERO;
            end
        endcase
    end

    // FSM state, wait counter and the bus-error pulse register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= CNT_ZERO;
            bus_err_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            bus_err_r  <= abandon_s | misalign_s;
        end
    end

    // Payload offered to the DM/WB register when the instruction retires
    always_comb begin
        w_next_s            = DM_WB_BUBBLE;
        w_next_s.reg_write  = RegWriteM;
        w_next_s.result_src = ResultSrcM;
        w_next_s.alu_result = ALUResultM;
        w_next_s.read_data  = load_data_s;
        w_next_s.pc_plus4   = PCPlus4M;
        w_next_s.rd         = RdM;
    end

    dm_wb_reg u_dm_wb_reg (
        .clk    (clk),
        .rst    (rst),
        .bubble (bubble_s),
        .d      (w_next_s),
        .q      (w_q_s)
    );

    assign RegWriteW  = w_q_s.reg_write;
    assign ResultSrcW = w_q_s.result_src;
    assign ALUResultW = w_q_s.alu_result;
    assign ReadDataW  = w_q_s.read_data;
    assign PCPlus4W   = w_q_s.pc_plus4;
    assign RdW        = w_q_s.rd;

endmodule
